// File: rtl/mem_dot_product.sv
// Signed MAC dot product over (activation, weight) word pairs streamed from the
// sequential-read memory. Optional ReLU on the result: define MEM_DOT_RELU_EN.
module mem_dot_product #(
  parameter int LEN_W = 9,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  output logic             busy,
  input  logic             multi_cycle_mode,
  input  logic [1:0]       cycle_count,
  output logic             mem_rd_en,
  input  logic [15:0]      mem_rdata,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    CAP_A = 3'd2,
    RD_B  = 3'd3,
    CAP_B = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               wait_q, wait_d;
  logic [LEN_W-1:0]         pairs_q, pairs_d;
  logic signed [15:0]       act_q, act_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]         res_q, res_d;

  logic [1:0]               wait_lim;
  logic                     wait_last;
  logic signed [31:0]       act_ext, rdata_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_sum;
  logic [ACC_W-1:0]         res_sel;

  // Timing inputs are sampled live; >= keeps the wait bounded if they change mid-read.
  assign wait_lim  = multi_cycle_mode ? cycle_count : 2'd0;
  assign wait_last = (wait_q >= wait_lim);

  assign act_ext   = {{16{act_q[15]}}, act_q};
  assign rdata_ext = {{16{mem_rdata[15]}}, mem_rdata};
  assign prod      = act_ext * rdata_ext;
  assign prod_ext  = ACC_W'(prod);
  assign acc_sum   = acc_q + prod_ext;

`ifdef MEM_DOT_RELU_EN
  assign res_sel = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
  assign res_sel = acc_sum;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      pairs_q <= '0;
      act_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pairs_q <= pairs_d;
      act_q   <= act_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pairs_d   = pairs_q;
    act_d     = act_q;
    acc_d     = acc_q;
    res_d     = res_q;
    mem_rd_en = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          res_d   = '0;
          wait_d  = '0;
          pairs_d = length;
          state_d = (length == '0) ? DONE : RD_A;
        end
      end
      RD_A: begin
        mem_rd_en = 1'b1;
        if (wait_last) begin
          wait_d  = '0;
          state_d = CAP_A;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      CAP_A: begin
        act_d   = $signed(mem_rdata);
        wait_d  = '0;
        state_d = RD_B;
      end
      RD_B: begin
        mem_rd_en = 1'b1;
        if (wait_last) begin
          wait_d  = '0;
          state_d = CAP_B;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      CAP_B: begin
        acc_d   = acc_sum;
        pairs_d = pairs_q - LEN_W'(1);
        wait_d  = '0;
        if (pairs_q == LEN_W'(1)) begin
          res_d   = res_sel;
          state_d = DONE;
        end else begin
          state_d = RD_A;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign res_data = res_q;

endmodule

// File: tb/tb_mem_dot_product.sv
// Directed bench for mem_dot_product: behavioural sequential-read memory,
// default (ACC_W=40) and ACC_W=32 instances sharing all inputs.
module tb_mem_dot_product;
  localparam int LEN_W = 9;
  localparam int ACC_W = 40;
`ifdef MEM_DOT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [LEN_W-1:0] length;
  logic             multi_cycle_mode;
  logic [1:0]       cycle_count;
  logic             res_ready;
  logic [15:0]      mem_rdata;
  logic             busy, mem_rd_en, res_valid;
  logic [ACC_W-1:0] res_data;
  logic             busy32, mem_rd_en32, res_valid32;
  logic [31:0]      res_data32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_dot_product #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .length(length), .busy(busy),
    .multi_cycle_mode(multi_cycle_mode), .cycle_count(cycle_count),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
  );

  mem_dot_product #(.LEN_W(LEN_W), .ACC_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .start(start), .length(length), .busy(busy32),
    .multi_cycle_mode(multi_cycle_mode), .cycle_count(cycle_count),
    .mem_rd_en(mem_rd_en32), .mem_rdata(mem_rdata), .res_valid(res_valid32),
    .res_ready(res_ready), .res_data(res_data32)
  );

  // Memory model: output register loads the next word at the end of the last
  // of W consecutive read-enable cycles.
  logic [15:0] mem [0:7];
  int          ptr;
  logic [1:0]  mrd_cnt;
  logic        mem_rewind;
  logic [1:0]  mem_w_m1;
  assign mem_w_m1 = multi_cycle_mode ? cycle_count : 2'd0;

  always @(posedge clk) begin
    if (mem_rewind) begin
      ptr     <= 0;
      mrd_cnt <= 2'd0;
    end else if (mem_rd_en) begin
      if (mrd_cnt == mem_w_m1) begin
        mem_rdata <= mem[ptr[2:0]];
        ptr       <= ptr + 1;
        mrd_cnt   <= 2'd0;
      end else begin
        mrd_cnt <= mrd_cnt + 2'd1;
      end
    end else begin
      mrd_cnt <= 2'd0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rewind();
    mem_rewind = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rewind = 1'b0;
  endtask

  // Called at a negedge. Returns the cycle (after the accepting edge) in which
  // res_valid first rises, or -1, plus the number of cycles whose read-enable /
  // busy differed from the expected 2W+2 per-pair pattern.
  task automatic run_op(input int n, input bit mc, input logic [1:0] cc,
                        output int valid_cyc, output int seq_err);
    int w, per, r;
    logic exp_rd;
    multi_cycle_mode = mc;
    cycle_count      = cc;
    length           = LEN_W'(n);
    start            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    w         = mc ? int'(cc) + 1 : 1;
    per       = 2 * w + 2;
    valid_cyc = -1;
    seq_err   = 0;
    for (int k = 1; k <= 300; k++) begin
      r      = (k - 1) % per;
      exp_rd = (k <= n * per) && ((r < w) || (r > w && r <= 2 * w));
      if (mem_rd_en !== exp_rd) seq_err++;
      if (mem_rd_en32 !== exp_rd) seq_err++;
      if (busy !== 1'b1) seq_err++;
      if (res_valid === 1'b1) begin
        valid_cyc = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic hs_done(input string t);
    @(posedge clk);
    @(negedge clk);
    check_eq({t, "_busy_after"}, busy, 1'b0);
    check_eq({t, "_valid_after"}, res_valid, 1'b0);
  endtask

  initial begin
    int vc, se, errs;
    logic [ACC_W-1:0] e40;
    logic [31:0]      e32;

    reset_n = 1'b0; start = 1'b0; length = '0; multi_cycle_mode = 1'b0;
    cycle_count = 2'd0; res_ready = 1'b1; mem_rewind = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_rd_en", mem_rd_en, 1'b0);
    check_eq("rst_valid", res_valid, 1'b0);
    check_eq("rst_data", res_data, '0);
    reset_n = 1'b1;
    mem_rewind = 1'b0;
    @(negedge clk);

    // single-cycle reads: 3*4 + (-2)*5 = 2
    mem[0] = 16'd3; mem[1] = 16'd4; mem[2] = 16'hFFFE; mem[3] = 16'd5;
    rewind();
    run_op(2, 1'b0, 2'd0, vc, se);
    check_eq("t1_valid_cyc", vc, 9);
    check_eq("t1_seq", se, 0);
    check_eq("t1_data", res_data, 40'd2);
    check_eq("t1_data32", res_data32, 32'd2);
    hs_done("t1");
    check_eq("t1_data_held", res_data, 40'd2);

    // multi-cycle, W=3
    rewind();
    run_op(2, 1'b1, 2'd2, vc, se);
    check_eq("t2_valid_cyc", vc, 17);
    check_eq("t2_seq", se, 0);
    check_eq("t2_data", res_data, 40'd2);
    hs_done("t2");

    // negative result: -3*4 = -12
    mem[0] = 16'hFFFD; mem[1] = 16'd4;
    rewind();
    run_op(1, 1'b0, 2'd0, vc, se);
    e40 = RELU ? 40'd0 : 40'hFF_FFFF_FFF4;
    check_eq("t3_valid_cyc", vc, 5);
    check_eq("t3_seq", se, 0);
    check_eq("t3_data", res_data, e40);
    hs_done("t3");

    // zero length
    run_op(0, 1'b0, 2'd0, vc, se);
    check_eq("t4_valid_cyc", vc, 1);
    check_eq("t4_seq", se, 0);
    check_eq("t4_data", res_data, 40'd0);
    hs_done("t4");

    // backpressure: 6*7 = 42, DONE held 5 cycles with start pulses ignored
    mem[0] = 16'd6; mem[1] = 16'd7;
    rewind();
    res_ready = 1'b0;
    run_op(1, 1'b0, 2'd0, vc, se);
    check_eq("t5_valid_cyc", vc, 5);
    check_eq("t5_data", res_data, 40'd42);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      start  = 1'b1;
      length = LEN_W'(3);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (res_valid !== 1'b1) errs++;
      if (res_data !== 40'd42) errs++;
      if (mem_rd_en !== 1'b0) errs++;
      if (busy !== 1'b1) errs++;
    end
    check_eq("t5_bp_stable", errs, 0);
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("t5_busy_after_hs", busy, 1'b0);
    check_eq("t5_valid_after_hs", res_valid, 1'b0);
    check_eq("t5_data_held", res_data, 40'd42);
    @(negedge clk);
    check_eq("t5_still_idle", busy, 1'b0);
    check_eq("t5_no_rd", mem_rd_en, 1'b0);

    // wrap: 2 * (-32768)^2 = 2^31, wraps only in the 32-bit accumulator
    mem[0] = 16'h8000; mem[1] = 16'h8000; mem[2] = 16'h8000; mem[3] = 16'h8000;
    rewind();
    run_op(2, 1'b0, 2'd0, vc, se);
    e32 = RELU ? 32'd0 : 32'h8000_0000;
    check_eq("t6_valid_cyc", vc, 9);
    check_eq("t6_valid32", res_valid32, 1'b1);
    check_eq("t6_data40", res_data, 40'h00_8000_0000);
    check_eq("t6_data32_wrap", res_data32, e32);
    hs_done("t6");

    // reset asserted in RD_B, then a fresh run
    mem[0] = 16'd3; mem[1] = 16'd4; mem[2] = 16'hFFFE; mem[3] = 16'd5;
    rewind();
    length = LEN_W'(2);
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t7_in_rd_b", mem_rd_en, 1'b1);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("t7_rst_busy", busy, 1'b0);
    check_eq("t7_rst_rd_en", mem_rd_en, 1'b0);
    check_eq("t7_rst_valid", res_valid, 1'b0);
    check_eq("t7_rst_data", res_data, '0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("t7_idle", busy, 1'b0);
    rewind();
    run_op(2, 1'b0, 2'd0, vc, se);
    check_eq("t7_valid_cyc", vc, 9);
    check_eq("t7_seq", se, 0);
    check_eq("t7_data", res_data, 40'd2);
    hs_done("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_dot_product.md
# mem_dot_product

Downstream consumer of the on-chip activation/weight memory. It drives the memory's sequential read-enable, honours the memory's single-cycle or multi-cycle read timing, and pairs the words it reads as (activation, weight). It computes a signed multiply-accumulate dot product over a programmed number of pairs. The result goes to the next neuron stage over a valid/ready handshake.

## Interface
Parameters:
- LEN_W, 9, width of pair-count input (up to 511 pairs = 1022 words)
- ACC_W, 40, accumulator/result width; legal range ≥ 32

Ports:
- clk  input  1  clock
- reset_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request to begin a dot product; ignored while busy=1
- length  input  LEN_W  number of (activation, weight) pairs; sampled on accepted start
- busy  output  1  high from the cycle after an accepted start until the result handshake completes
- multi_cycle_mode  input  1  same signal as driven to the memory
- cycle_count  input  2  same signal as driven to the memory
- mem_rd_en  output  1  read enable to memory
- mem_rdata  input  16  memory data_out
- res_valid  output  1  result available
- res_ready  input  1  downstream accepts result
- res_data  output  ACC_W  signed dot-product result

## Operation
- States: IDLE, RD_A, CAP_A, RD_B, CAP_B, DONE.
- IDLE:
  - start=1 with length≠0 → RD_A. Clears the accumulator, loads the pair counter, sets busy.
  - start=1 with length=0 → DONE with accumulator 0.
- RD_A / RD_B hold mem_rd_en=1 for W cycles, then advance to CAP_A / CAP_B.
  - W = cycle_count+1 when multi_cycle_mode=1, else 1.
  - A 2-bit wait counter counts the W cycles; it is cleared on entry to each RD state.
- CAP_A: mem_rd_en=0; latches mem_rdata as the signed activation → RD_B.
- CAP_B: mem_rd_en=0.
  - acc ← acc + sext(act × mem_rdata). The product is signed 16×16→32, sign-extended to ACC_W.
  - The sum wraps modulo 2^ACC_W.
  - Decrements the pair counter. If the counter is now 0 → DONE, else → RD_A.
- DONE: res_valid=1. res_data = final accumulator (post-processed per Configuration).
  - res_valid=1 && res_ready=1 → IDLE; busy drops the following cycle.
- res_data holds its value after the handshake until the next accepted start.
- multi_cycle_mode and cycle_count are sampled live. The integrator holds them stable while busy=1. A change mid-operation gives undefined pairing but must not hang the FSM.
- No memory address is driven; word order is the memory's internal address order.
- Reset values: mem_rd_en=0, busy=0, res_valid=0, res_data=0, state IDLE, accumulator/counters 0.
- reset_n low in any state aborts immediately to these values. No result is produced.

## Timing
- Start accepted on rising edge E0. First mem_rd_en=1 cycle is the cycle after E0.
- mem_rdata is valid in the CAP cycle directly following the last RD cycle, which is one cycle after the memory's registered output update.
- Cycles per pair: 2W+2.
- res_valid first high in cycle N·(2W+2)+1 after E0.
- length=0: res_valid high in the cycle after E0.
- Back-to-back operation:
  - start in the same cycle as the result handshake is ignored (busy still 1).
  - The earliest accepted start is in the cycle busy=0.
- res_ready low holds DONE indefinitely. res_data stays stable and mem_rd_en stays 0.

## Configuration
- MEM_DOT_RELU_EN defined: the result passes through ReLU; negative accumulators are presented as res_data=0. The adder is unchanged.
- MEM_DOT_RELU_EN undefined: res_data is the raw signed accumulator.

## Test plan
- Single-cycle, memory preloaded [3, 4, -2, 5], length=2 → mem_rd_en pulses in cycles 1, 3, 5, 7. res_valid in cycle 9, res_data=2.
- Multi-cycle, cycle_count=2 (W=3), same data → mem_rd_en high 3 consecutive cycles per word. res_valid in cycle 17, res_data=2.
- Data [-3, 4], length=1 → res_data=-12 without MEM_DOT_RELU_EN, 0 with it. res_valid in cycle 5.
- length=0 → res_valid in cycle 1, res_data=0, no mem_rd_en pulse.
- Backpressure: res_ready low 5 cycles in DONE → res_valid and res_data stable; start pulses ignored. Idle after the handshake.
- ACC_W=32, data [-32768, -32768] ×2, length=2 → res_data=0x80000000 (wrap). Separately, reset_n asserted in RD_B → all outputs 0 next cycle, FSM idle, a fresh start works normally.
